// File: rtl/fifo_read_drain.sv
// Read-domain burst consumer: pops i_len words from a FWFT async FIFO and
// replays them as a valid/ready stream through a 2-entry output buffer.
//
// state | meaning
// IDLE  | waiting for i_start
// BUSY  | popping while words remain, watching for empty stalls
// FLUSH | no more pops; waiting for the output buffer to drain
// DONE  | one-cycle o_done / o_err pulse
module fifo_read_drain #(
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst_n,
    input  logic                  i_start,
    input  logic [LEN_W-1:0]      i_len,
    output logic                  o_busy,
    output logic                  o_rinc,
    input  logic                  i_rempty,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_done,
    output logic                  o_err,
    output logic [LEN_W-1:0]      o_count
);
    localparam int            SW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STALL_LOAD = SW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH, DONE} state_t;

    state_t                  state, state_nx;
    logic [LEN_W-1:0]        rem;
    logic [SW-1:0]           stall_left;
    logic                    abort;
    logic [DATA_WIDTH-1:0]   buf_data [2];
    logic                    buf_tag  [2];
    logic                    wptr, rptr;
    logic [1:0]              buf_cnt;
    logic                    pop, take, stall_cyc, timeout_hit;

    assign pop         = (state == BUSY) && (rem != '0) && !i_rempty && (buf_cnt != 2'd2);
    assign stall_cyc   = (state == BUSY) && (rem != '0) && i_rempty;
    assign timeout_hit = stall_cyc && (stall_left == SW'(1));
    assign o_valid     = (buf_cnt != 2'd0);
    assign take        = o_valid && i_ready;
    assign o_data      = buf_data[rptr];
    assign o_last      = buf_tag[rptr] && o_valid;

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_err    = 1'b0;
        o_rinc   = pop;
        case (state)
            IDLE: begin
                if (i_start) state_nx = (i_len == '0) ? DONE : BUSY;
            end
            BUSY: begin
                o_busy = 1'b1;
                if ((pop && rem == LEN_W'(1)) || timeout_hit) state_nx = FLUSH;
            end
            FLUSH: begin
                o_busy = 1'b1;
                if (buf_cnt == 2'd0) state_nx = DONE;
            end
            DONE: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                o_err    = abort;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stall timer counts down from TIMEOUT_CYCLES; reloaded by every pop.
    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            rem        <= '0;
            o_count    <= '0;
            stall_left <= '0;
            abort      <= 1'b0;
        end else if (state == IDLE && i_start) begin
            rem        <= i_len;
            o_count    <= '0;
            stall_left <= STALL_LOAD;
            abort      <= 1'b0;
        end else if (pop) begin
            rem        <= rem - LEN_W'(1);
            o_count    <= o_count + LEN_W'(1);
            stall_left <= STALL_LOAD;
        end else if (stall_cyc) begin
            if (stall_left == SW'(1)) abort <= 1'b1;
            else                      stall_left <= stall_left - SW'(1);
        end
    end

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_tag[0]  <= 1'b0;
            buf_tag[1]  <= 1'b0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            buf_cnt     <= 2'd0;
        end else begin
            if (pop) begin
                buf_data[wptr] <= i_rdata;
                buf_tag[wptr]  <= (rem == LEN_W'(1));
                wptr           <= ~wptr;
            end
            if (take) rptr <= ~rptr;
            case ({pop, take})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: a queue stands in for the async FIFO and a
// cycle-level reference of the burst rules predicts every output.
module tb_fifo_read_drain;
    localparam int DW = 8;
    localparam int LW = 16;
    localparam int TO = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy, rinc, valid, last, done, err;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          ready = 1'b1;
    logic [DW-1:0] data;
    logic [LW-1:0] count;

    always #5 clk = ~clk;

    fifo_read_drain #(.DATA_WIDTH(DW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)) dut (
        .i_rclk(clk), .i_rrst_n(rst_n), .i_start(start), .i_len(len),
        .o_busy(busy), .o_rinc(rinc), .i_rempty(rempty), .i_rdata(rdata),
        .o_valid(valid), .i_ready(ready), .o_data(data), .o_last(last),
        .o_done(done), .o_err(err), .o_count(count)
    );

    typedef struct packed { logic [DW-1:0] d; logic l; } item_t;

    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] fq[$];
    item_t sb[$];
    item_t outq[$];

    // reference burst state
    bit fetching, draining, done_now, aborted;
    int L, pops, occ, stall, cyc;
    // stimulus / observation
    int rdy_mode, rdy_phase, push_pct;
    bit rst_on_pop3;
    int dones, last_err, last_cnt, done_cyc, start_cyc;
    int first_rinc, first_valid, n_rinc, rinc_run, rinc_max, last_pop_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        fetching = 0; draining = 0; done_now = 0; aborted = 0;
        L = 0; pops = 0; occ = 0; stall = 0;
        sb.delete();
    endtask

    task automatic set_fifo_pins();
        rempty = (fq.size() == 0);
        rdata  = rempty ? '0 : fq[0];
    endtask

    task automatic obs_clear();
        outq.delete();
        first_rinc = -1; first_valid = -1; n_rinc = 0; rinc_run = 0; rinc_max = 0;
    endtask

    task automatic drive_next();
        start = 1'b0;
        if (push_pct > 0 && fq.size() < 6 && $urandom_range(99) < push_pct)
            fq.push_back(8'($urandom));
        case (rdy_mode)
            0:       ready = 1'b1;
            1:       begin rdy_phase++; ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3); end
            default: ready = 1'($urandom_range(1));
        endcase
        set_fifo_pins();
    endtask

    task automatic tick();
        bit pop_now, take_now, idle;
        item_t it;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            check_eq("reset_outputs", 32'({busy, rinc, valid, last, done, err, data, count}), 32'd0);
            @(posedge clk); #1;
            drive_next();
            return;
        end
        idle     = !(fetching || draining || done_now);
        pop_now  = fetching && fq.size() != 0 && occ < 2;
        take_now = (occ != 0) && ready;
        check_eq("rinc", 32'(rinc), 32'(pop_now));
        check_eq("busy", 32'(busy), 32'(!idle));
        check_eq("valid", 32'(valid), 32'(occ != 0));
        if (occ != 0) begin
            check_eq("data", 32'(data), 32'(sb[0].d));
            check_eq("last", 32'(last), 32'(sb[0].l));
        end
        check_eq("done", 32'(done), 32'(done_now));
        check_eq("err", 32'(err), 32'(done_now && aborted));
        check_eq("count", 32'(count), 32'(pops));
        if (rinc) begin
            n_rinc++; rinc_run++;
            if (rinc_run > rinc_max) rinc_max = rinc_run;
            if (first_rinc < 0) first_rinc = cyc;
        end else rinc_run = 0;
        if (valid && first_valid < 0) first_valid = cyc;
        if (done) begin dones++; last_err = int'(err); last_cnt = int'(count); done_cyc = cyc; end

        if (rst_on_pop3 && fetching && pops == 2 && rinc) begin
            rst_on_pop3 = 0;
            rst_n = 1'b0;
            #1;
            check_eq("async_reset", 32'({busy, rinc, valid, last, done, err, data, count}), 32'd0);
            model_clear();
            @(posedge clk); #1;
            drive_next();
            return;
        end

        if (done_now) done_now = 0;
        else if (draining) begin
            if (occ == 0) begin draining = 0; done_now = 1; end
        end else if (fetching) begin
            if (pop_now) begin
                pops++; stall = 0; last_pop_cyc = cyc;
                it.d = fq[0]; it.l = (pops == L);
                sb.push_back(it);
                if (pops == L) begin fetching = 0; draining = 1; end
            end else if (fq.size() == 0) begin
                stall++;
                if (stall == TO) begin aborted = 1; fetching = 0; draining = 1; end
            end
        end else if (start) begin
            L = int'(len); pops = 0; aborted = 0; stall = 0;
            if (L == 0) done_now = 1; else fetching = 1;
        end
        if (take_now) begin
            it.d = data; it.l = last;
            outq.push_back(it);
            void'(sb.pop_front());
        end
        occ += int'(pop_now) - int'(take_now);

        @(posedge clk); #1;
        if (pop_now) void'(fq.pop_front());
        drive_next();
    endtask

    task automatic preload(input int n, input int base);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(8'(base + i));
        set_fifo_pins();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = dones;
        for (int i = 0; i < budget && dones == d0; i++) tick();
        check_eq({tag, "_done_seen"}, 32'(dones != d0), 32'd1);
    endtask

    task automatic issue(input int l);
        obs_clear();
        start = 1'b1; len = LW'(l);
        start_cyc = cyc + 1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_clear(); obs_clear();
        cyc = 0; dones = 0; rdy_mode = 0; rdy_phase = 0; push_pct = 0; rst_on_pop3 = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // full-rate burst
        preload(8, 8'h10);
        issue(8);
        wait_done("full", 60);
        check_eq("full_rinc_run", 32'(rinc_max), 32'd8);
        check_eq("full_rinc_latency", 32'(first_rinc - start_cyc), 32'd1);
        check_eq("full_valid_latency", 32'(first_valid - start_cyc), 32'd2);
        check_eq("full_words", 32'(outq.size()), 32'd8);
        for (int i = 0; i < outq.size(); i++) begin
            check_eq("full_word", 32'(outq[i].d), 32'(8'h10 + i));
            check_eq("full_last", 32'(outq[i].l), 32'(i == 7));
        end
        check_eq("full_err", 32'(last_err), 32'd0);
        check_eq("full_count", 32'(last_cnt), 32'd8);

        // backpressure with ready 1,0,0,1,...
        preload(4, 8'hC4);
        rdy_mode = 1; rdy_phase = 0; ready = 1'b1;
        issue(4);
        wait_done("bp", 80);
        check_eq("bp_words", 32'(outq.size()), 32'd4);
        for (int i = 0; i < outq.size(); i++) check_eq("bp_order", 32'(outq[i].d), 32'(8'hC4 + i));
        check_eq("bp_count", 32'(last_cnt), 32'd4);
        rdy_mode = 0; ready = 1'b1;

        // empty stall that ends one cycle short of the timeout
        preload(1, 8'hA0);
        issue(3);
        for (int i = 0; i < 100 && stall != TO - 1; i++) tick();
        check_eq("stall_reached", 32'(stall), 32'(TO - 1));
        fq.push_back(8'hA1); set_fifo_pins();
        tick();
        fq.push_back(8'hA2); set_fifo_pins();
        wait_done("recov", 60);
        check_eq("recov_err", 32'(last_err), 32'd0);
        check_eq("recov_count", 32'(last_cnt), 32'd3);
        check_eq("recov_words", 32'(outq.size()), 32'd3);
        if (outq.size() == 3) check_eq("recov_last", 32'(outq[2].l), 32'd1);

        // timeout abort
        preload(2, 8'h50);
        issue(5);
        wait_done("abort", 100);
        check_eq("abort_err", 32'(last_err), 32'd1);
        check_eq("abort_count", 32'(last_cnt), 32'd2);
        check_eq("abort_words", 32'(outq.size()), 32'd2);
        for (int i = 0; i < outq.size(); i++) check_eq("abort_no_last", 32'(outq[i].l), 32'd0);
        check_eq("abort_done_time", 32'(done_cyc - last_pop_cyc), 32'(TO + 2));

        // zero length
        preload(3, 8'h70);
        issue(0);
        wait_done("zero", 5);
        check_eq("zero_done_time", 32'(done_cyc - start_cyc), 32'd1);
        check_eq("zero_no_rinc", 32'(n_rinc), 32'd0);
        check_eq("zero_err", 32'(last_err), 32'd0);

        // start while busy is ignored
        preload(6, 8'h30);
        rdy_mode = 2;
        issue(6);
        tick();
        start = 1'b1; len = LW'(2);
        tick();
        wait_done("ign", 80);
        check_eq("ign_count", 32'(last_cnt), 32'd6);
        check_eq("ign_words", 32'(outq.size()), 32'd6);
        check_eq("ign_err", 32'(last_err), 32'd0);
        rdy_mode = 0; ready = 1'b1;

        // reset during the third pop
        preload(8, 8'h80);
        rst_on_pop3 = 1;
        begin
            int d0;
            d0 = dones;
            issue(8);
            for (int i = 0; i < 40 && rst_n; i++) tick();
            check_eq("reset_hit", 32'(rst_n), 32'd0);
            tick(); tick(); tick();
            rst_n = 1'b1;
            tick(); tick();
            check_eq("reset_no_done", 32'(dones), 32'(d0));
        end
        preload(2, 8'hE0);
        issue(2);
        wait_done("post_rst", 30);
        check_eq("post_rst_count", 32'(last_cnt), 32'd2);
        check_eq("post_rst_err", 32'(last_err), 32'd0);

        // randomized bursts with random FIFO arrivals and sink readiness
        fq.delete(); set_fifo_pins();
        push_pct = 60; rdy_mode = 2;
        for (int b = 0; b < 8; b++) begin
            int l;
            l = int'($urandom_range(12, 1));
            issue(l);
            wait_done("rand", 400);
        end
        push_pct = 0; rdy_mode = 0; ready = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
